// File: rtl/bus_decoder.sv
// Memory-bus interconnect: decodes the master address against per-slave base/mask
// windows, runs a valid/ready handshake with the selected slave, and faults on unmapped or timed-out accesses.
module bus_decoder #(
    parameter int                     NUM_SLAVES     = 4,
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE   = {NUM_SLAVES{32'h0}},
    parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK   = {NUM_SLAVES{32'hffff0000}},
    parameter int                     TIMEOUT_CYCLES = 255,
    parameter int                     TIMEOUT_WIDTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       mem_valid_in,
    input  logic [31:0]                mem_address_in,
    input  logic [3:0]                 mem_write_mask_in,
    input  logic [31:0]                mem_write_value_in,
    output logic                       mem_ready_out,
    output logic                       mem_fault_out,
    output logic [31:0]                mem_read_value_out,
    output logic [NUM_SLAVES-1:0]      slave_sel_out,
    output logic [31:0]                slave_address_out,
    output logic [3:0]                 slave_write_mask_out,
    output logic [31:0]                slave_write_value_out,
    input  logic [NUM_SLAVES-1:0]      slave_ready_in,
    input  logic [32*NUM_SLAVES-1:0]   slave_read_value_in
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        FAULT
    } state_t;

    state_t                   state;
    logic [TIMEOUT_WIDTH-1:0] timeout_count;
    logic                     hit_found;
    logic [IDX_W-1:0]         hit_idx;
    logic                     sel_ready;
    logic [31:0]              sel_read_value;

    // Scanning downwards lets the lowest-indexed matching window win on overlap.
    always_comb begin
        hit_found = 1'b0;
        hit_idx   = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((mem_address_in & SLAVE_MASK[32*i +: 32]) ==
                (SLAVE_BASE[32*i +: 32] & SLAVE_MASK[32*i +: 32])) begin
                hit_found = 1'b1;
                hit_idx   = IDX_W'(i);
            end
        end
    end

    // The one-hot select register doubles as the stored slave index.
    always_comb begin
        sel_ready      = 1'b0;
        sel_read_value = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_sel_out[i]) begin
                sel_ready      = slave_ready_in[i];
                sel_read_value = slave_read_value_in[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= IDLE;
            timeout_count         <= '0;
            mem_ready_out         <= 1'b0;
            mem_fault_out         <= 1'b0;
            mem_read_value_out    <= '0;
            slave_sel_out         <= '0;
            slave_address_out     <= '0;
            slave_write_mask_out  <= '0;
            slave_write_value_out <= '0;
        end else begin
            mem_ready_out      <= 1'b0;
            mem_fault_out      <= 1'b0;
            mem_read_value_out <= '0;
            case (state)
                IDLE: begin
                    if (mem_valid_in) begin
                        slave_address_out     <= mem_address_in;
                        slave_write_value_out <= mem_write_value_in;
                        timeout_count         <= '0;
                        if (hit_found) begin
                            slave_sel_out        <= NUM_SLAVES'(1) << hit_idx;
                            slave_write_mask_out <= mem_write_mask_in;
                            state                <= BUSY;
                        end else begin
                            mem_ready_out <= 1'b1;
                            mem_fault_out <= 1'b1;
                            state         <= FAULT;
                        end
                    end
                end
                // A ready arriving on the last allowed cycle still completes normally.
                BUSY: begin
                    if (sel_ready) begin
                        mem_ready_out        <= 1'b1;
                        mem_read_value_out   <= sel_read_value;
                        slave_sel_out        <= '0;
                        slave_write_mask_out <= '0;
                        state                <= DONE;
                    end else if (timeout_count == TIMEOUT_LAST) begin
                        mem_ready_out        <= 1'b1;
                        mem_fault_out        <= 1'b1;
                        slave_sel_out        <= '0;
                        slave_write_mask_out <= '0;
                        state                <= FAULT;
                    end else begin
                        timeout_count <= timeout_count + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                FAULT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_decoder.sv
// Scoreboard bench for bus_decoder: a driver pushes expected completions, a monitor
// pops and compares them, and a small slave responder answers after a chosen number of BUSY cycles.
module tb_bus_decoder;

    localparam int N = 4;

    typedef struct {
        logic        fault;
        logic [31:0] data;
        int          latency;
        int          issue_cycle;
    } exp_t;

    logic                clk;
    logic                reset_n;
    logic                mem_valid_in;
    logic [31:0]         mem_address_in;
    logic [3:0]          mem_write_mask_in;
    logic [31:0]         mem_write_value_in;
    logic                mem_ready_out;
    logic                mem_fault_out;
    logic [31:0]         mem_read_value_out;
    logic [N-1:0]        slave_sel_out;
    logic [31:0]         slave_address_out;
    logic [3:0]          slave_write_mask_out;
    logic [31:0]         slave_write_value_out;
    logic [N-1:0]        slave_ready_in;
    logic [32*N-1:0]     slave_read_value_in;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle_cnt = 0;
    int          busy_cnt = 0;
    int          resp_delay = 0;
    logic [N-1:0] decoy = '0;
    logic [N-1:0] exp_sel = '0;
    logic [3:0]  exp_mask = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_wdata = '0;

    bus_decoder #(
        .NUM_SLAVES    (N),
        .SLAVE_BASE    ({32'h0001_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000}),
        .SLAVE_MASK    ({32'hfff0_0000, 32'hffff_0000, 32'hffff_0000, 32'hffff_0000}),
        .TIMEOUT_CYCLES(4),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .mem_valid_in         (mem_valid_in),
        .mem_address_in       (mem_address_in),
        .mem_write_mask_in    (mem_write_mask_in),
        .mem_write_value_in   (mem_write_value_in),
        .mem_ready_out        (mem_ready_out),
        .mem_fault_out        (mem_fault_out),
        .mem_read_value_out   (mem_read_value_out),
        .slave_sel_out        (slave_sel_out),
        .slave_address_out    (slave_address_out),
        .slave_write_mask_out (slave_write_mask_out),
        .slave_write_value_out(slave_write_value_out),
        .slave_ready_in       (slave_ready_in),
        .slave_read_value_in  (slave_read_value_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    assign slave_read_value_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hdead_beef};

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Slave responder: raises ready on the selected slave on BUSY cycle resp_delay (0 = never).
    initial begin
        slave_ready_in = '0;
        forever begin
            @(negedge clk);
            if (slave_sel_out != '0) busy_cnt = busy_cnt + 1;
            else busy_cnt = 0;
            if (slave_sel_out == '0) slave_ready_in = '0;
            else if (busy_cnt == resp_delay) slave_ready_in = slave_sel_out | decoy;
            else slave_ready_in = decoy;
        end
    end

    // Monitor: compares every completion against the scoreboard and every selected cycle against the request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (slave_sel_out != '0) begin
                    checkOutput("sel", 32'(slave_sel_out), 32'(exp_sel));
                    checkOutput("slave_mask", 32'(slave_write_mask_out), 32'(exp_mask));
                    checkOutput("slave_addr", slave_address_out, exp_addr);
                    checkOutput("slave_wdata", slave_write_value_out, exp_wdata);
                end else begin
                    checkOutput("mask_idle", 32'(slave_write_mask_out), 32'h0);
                end
                if (mem_ready_out) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_ready", 32'h1, 32'h0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("fault", 32'(mem_fault_out), 32'(e.fault));
                        checkOutput("read_value", mem_read_value_out, e.data);
                        checkOutput("latency", 32'(cycle_cnt - e.issue_cycle), 32'(e.latency));
                    end
                end else begin
                    checkOutput("fault_without_ready", 32'(mem_fault_out), 32'h0);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] wmask, input logic [31:0] wdata,
                                 input int delay, input logic [N-1:0] dec, input bit hold,
                                 input logic [N-1:0] sel, input logic fault, input logic [31:0] data,
                                 input int latency);
        exp_t e;
        bit   seen = 0;
        @(negedge clk);
        resp_delay = delay;
        decoy      = dec;
        exp_sel    = sel;
        exp_mask   = wmask;
        exp_addr   = addr;
        exp_wdata  = wdata;
        e.fault = fault;
        e.data = data;
        e.latency = latency;
        e.issue_cycle = cycle_cnt;
        exp_q.push_back(e);
        mem_valid_in       = 1'b1;
        mem_address_in     = addr;
        mem_write_mask_in  = wmask;
        mem_write_value_in = wdata;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!hold) mem_valid_in = 1'b0;
            if (mem_ready_out) seen = 1;
        end
        mem_valid_in = 1'b0;
        decoy = '0;
        if (!seen) begin
            checkOutput("completion_timeout", 32'h0, 32'h1);
            exp_q.delete();
        end
    endtask

    initial begin
        bit got_sel = 0;
        reset_n = 1'b0;
        mem_valid_in = 1'b0;
        mem_address_in = '0;
        mem_write_mask_in = '0;
        mem_write_value_in = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(mem_ready_out), 32'h0);
        checkOutput("rst_fault", 32'(mem_fault_out), 32'h0);
        checkOutput("rst_read", mem_read_value_out, 32'h0);
        checkOutput("rst_sel", 32'(slave_sel_out), 32'h0);
        checkOutput("rst_addr", slave_address_out, 32'h0);
        checkOutput("rst_mask", 32'(slave_write_mask_out), 32'h0);
        checkOutput("rst_wdata", slave_write_value_out, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] read slave 0 / write slave 2 / unmapped");
        applyStimulus(32'h0000_0010, 4'b0000, 32'h0, 1, '0, 1, 4'b0001, 1'b0, 32'hdead_beef, 2);
        applyStimulus(32'h0002_0004, 4'b0011, 32'hcafe_f00d, 2, '0, 1, 4'b0100, 1'b0, 32'h2222_2222, 3);
        applyStimulus(32'h8000_0000, 4'b0000, 32'h0, 1, '0, 1, 4'b0000, 1'b1, 32'h0, 1);
        applyStimulus(32'h8000_0000, 4'b1111, 32'h1234_5678, 1, '0, 1, 4'b0000, 1'b1, 32'h0, 1);

        $display("[TB] timeout boundary");
        applyStimulus(32'h0005_0000, 4'b0000, 32'h0, 0, '0, 1, 4'b1000, 1'b1, 32'h0, 5);
        applyStimulus(32'h0005_0000, 4'b0000, 32'h0, 4, '0, 1, 4'b1000, 1'b0, 32'h3333_3333, 5);
        applyStimulus(32'h0005_0000, 4'b0000, 32'h0, 3, '0, 1, 4'b1000, 1'b0, 32'h3333_3333, 4);

        $display("[TB] overlap, decoy ready, early valid drop");
        applyStimulus(32'h0001_0040, 4'b0000, 32'h0, 2, 4'b1000, 1, 4'b0010, 1'b0, 32'h1111_1111, 3);
        applyStimulus(32'h0001_0000, 4'b1111, 32'haaaa_5555, 3, '0, 0, 4'b0010, 1'b0, 32'h1111_1111, 4);

        $display("[TB] reset during BUSY");
        @(negedge clk);
        resp_delay = 0;
        exp_sel = 4'b0010;
        exp_mask = 4'b0000;
        exp_addr = 32'h0001_0000;
        exp_wdata = 32'h0;
        mem_valid_in = 1'b1;
        mem_address_in = 32'h0001_0000;
        mem_write_mask_in = 4'b0000;
        mem_write_value_in = 32'h0;
        for (int i = 0; i < 10 && !got_sel; i++) begin
            @(negedge clk);
            if (slave_sel_out != '0) got_sel = 1;
        end
        checkOutput("busy_reached", 32'(got_sel), 32'h1);
        reset_n = 1'b0;
        mem_valid_in = 1'b0;
        #1;
        checkOutput("rst_busy_sel", 32'(slave_sel_out), 32'h0);
        checkOutput("rst_busy_ready", 32'(mem_ready_out), 32'h0);
        checkOutput("rst_busy_addr", slave_address_out, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        applyStimulus(32'h0000_0010, 4'b0000, 32'h0, 1, '0, 1, 4'b0001, 1'b0, 32'hdead_beef, 2);

        repeat (4) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
